// File: rtl/i2c_regbank_pkg.sv
// Shared definitions for the I2C APB register bank: register offsets,
// STATUS bit positions and the ADDR register layout.
package i2c_regbank_pkg;

  localparam logic [7:0] ADDR_OFS   = 8'h00;
  localparam logic [7:0] STATUS_OFS = 8'h04;
  localparam logic [7:0] IRQ_EN_OFS = 8'h08;
  localparam logic [7:0] TXDATA_OFS = 8'h0C;
  localparam logic [7:0] RXDATA_OFS = 8'h10;

  localparam int NAK_BIT = 0;
  localparam int TRA_BIT = 1;
  localparam int REC_BIT = 2;
  localparam int OVR_BIT = 3;

  typedef struct packed {
    logic       tba;
    logic [9:0] slvaddr;
  } addr_reg_t;

endpackage

// File: rtl/i2c_byte_fifo.sv
// Byte FIFO with power-of-two depth. Full/empty are judged on the level at the
// start of the cycle, so a push to a full FIFO is dropped even if it also pops.
module i2c_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2c_regbank_fifo.sv
// APB register bank for the I2C controller: slave address, W1C sticky status,
// interrupt enables and TX/RX byte FIFOs. Zero wait states, errors on PSLVERR.
module i2c_regbank_fifo
  import i2c_regbank_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] i_PADDR,
  input  logic [APB_DATA_WIDTH-1:0] i_PWDATA,
  input  logic                      i_PWRITE,
  input  logic                      i_PSEL,
  input  logic                      i_PENABLE,
  output logic [APB_DATA_WIDTH-1:0] o_PRDATA,
  output logic                      o_PREADY,
  output logic                      o_PSLVERR,
  output logic                      o_irq,
  output logic                      o_tba,
  output logic [9:0]                o_slvaddr,
  output logic                      o_tx_valid,
  output logic [7:0]                o_tx_data,
  input  logic                      i_tx_ready,
  input  logic                      i_rx_valid,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_tra,
  input  logic                      i_nak
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  addr_reg_t     addr_q;
  logic [3:0]    status_q;
  logic [3:0]    status_nxt;
  logic [3:0]    irq_en_q;
  logic [3:0]    irq_en_nxt;
  logic [3:0]    status_set;
  logic [3:0]    status_clr;

  logic          access;
  logic          rd;
  logic          wr;
  logic          upper_zero;
  logic          hit_addr, hit_status, hit_irq_en, hit_tx, hit_rx;
  logic          mapped;
  logic          err;
  logic          wr_ok;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_dout;
  logic [LW-1:0] tx_level;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_dout;
  logic [LW-1:0] rx_level;

  logic          unused_pwdata;

  assign access     = i_PSEL && i_PENABLE;
  assign wr         = access && i_PWRITE;
  assign rd         = access && !i_PWRITE;
  assign upper_zero = ((i_PADDR >> 8) == '0);
  assign hit_addr   = upper_zero && (i_PADDR[7:0] == ADDR_OFS);
  assign hit_status = upper_zero && (i_PADDR[7:0] == STATUS_OFS);
  assign hit_irq_en = upper_zero && (i_PADDR[7:0] == IRQ_EN_OFS);
  assign hit_tx     = upper_zero && (i_PADDR[7:0] == TXDATA_OFS);
  assign hit_rx     = upper_zero && (i_PADDR[7:0] == RXDATA_OFS);
  assign mapped     = hit_addr || hit_status || hit_irq_en || hit_tx || hit_rx;

  assign err = access && (!mapped
                          || (i_PWRITE && hit_tx && tx_full)
                          || (!i_PWRITE && hit_rx && rx_empty));
  assign wr_ok = wr && !err;

  assign o_PREADY  = 1'b1;
  assign o_PSLVERR = err;

  always_comb begin
    o_PRDATA = '0;
    if (hit_addr)
      o_PRDATA = {addr_q.tba, 21'h0, addr_q.slvaddr};
    else if (hit_status)
      o_PRDATA = {12'h0, 4'(rx_level), 4'h0, 4'(tx_level), 4'h0, status_q};
    else if (hit_irq_en)
      o_PRDATA = {28'h0, irq_en_q};
    else if (hit_rx && !rx_empty)
      o_PRDATA = {24'h0, rx_dout};
  end

  assign tx_push = wr_ok && hit_tx;
  assign tx_pop  = o_tx_valid && i_tx_ready;
  assign rx_push = i_rx_valid && !rx_full;
  assign rx_pop  = rd && hit_rx && !rx_empty;

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (tx_push),
    .din     (i_PWDATA[7:0]),
    .pop     (tx_pop),
    .dout    (tx_dout),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_rx_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (rx_push),
    .din     (i_rx_data),
    .pop     (rx_pop),
    .dout    (rx_dout),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  assign o_tx_valid = !tx_empty;
  assign o_tx_data  = tx_dout;
  assign o_tba      = addr_q.tba;
  assign o_slvaddr  = addr_q.slvaddr;

  // Hardware set is OR'd in after the clear so it wins a same-cycle W1C.
  always_comb begin
    status_set          = '0;
    status_set[NAK_BIT] = i_nak;
    status_set[TRA_BIT] = i_tra;
    status_set[REC_BIT] = rx_push;
    status_set[OVR_BIT] = i_rx_valid && rx_full;
    status_clr          = (wr_ok && hit_status) ? i_PWDATA[3:0] : 4'h0;
    status_nxt          = (status_q & ~status_clr) | status_set;
    irq_en_nxt          = (wr_ok && hit_irq_en) ? i_PWDATA[3:0] : irq_en_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q   <= '0;
      status_q <= '0;
      irq_en_q <= '0;
      o_irq    <= 1'b0;
    end else begin
      if (wr_ok && hit_addr) begin
        addr_q.tba     <= i_PWDATA[31];
        addr_q.slvaddr <= i_PWDATA[9:0];
      end
      status_q <= status_nxt;
      irq_en_q <= irq_en_nxt;
      o_irq    <= |(status_nxt & irq_en_nxt);
    end
  end

  assign unused_pwdata = ^i_PWDATA[30:10];

endmodule

// File: tb/tb_i2c_regbank_fifo.sv
// Directed bench for i2c_regbank_fifo with hand-computed expectations.
module tb_i2c_regbank_fifo;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [31:0] prdata;
  logic        pready, pslverr, irq, tba;
  logic [9:0]  slvaddr;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0, rx_valid = 1'b0, tra = 1'b0, nak = 1'b0;
  logic [7:0]  rx_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  i2c_regbank_fifo #(.APB_ADDR_WIDTH(12), .APB_DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .i_PADDR    (paddr),
    .i_PWDATA   (pwdata),
    .i_PWRITE   (pwrite),
    .i_PSEL     (psel),
    .i_PENABLE  (penable),
    .o_PRDATA   (prdata),
    .o_PREADY   (pready),
    .o_PSLVERR  (pslverr),
    .o_irq      (irq),
    .o_tba      (tba),
    .o_slvaddr  (slvaddr),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .i_tra      (tra),
    .i_nak      (nak)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
    @(posedge HCLK); #1;
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(posedge HCLK); #1;
    penable = 1'b1;
    @(negedge HCLK);
    err = pslverr;
    @(posedge HCLK); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    @(posedge HCLK); #1;
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(posedge HCLK); #1;
    penable = 1'b1;
    @(negedge HCLK);
    d = prdata;
    err = pslverr;
    @(posedge HCLK); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;

    // Reset and initial state
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_tba", 32'(tba), 32'h0);
    chk("rst_slvaddr", 32'(slvaddr), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_pready", 32'(pready), 32'h1);

    apb_read(12'h000, d, e); chk("rst_addr", d, 32'h0); chk("rst_addr_err", 32'(e), 32'h0);
    apb_read(12'h004, d, e); chk("rst_status", d, 32'h0); chk("rst_status_err", 32'(e), 32'h0);
    apb_read(12'h008, d, e); chk("rst_irq_en", d, 32'h0); chk("rst_irq_en_err", 32'(e), 32'h0);
    apb_read(12'h00C, d, e); chk("rst_txdata", d, 32'h0); chk("rst_txdata_err", 32'(e), 32'h0);
    apb_read(12'h010, d, e); chk("rst_rxdata", d, 32'h0); chk("rst_rxdata_err", 32'(e), 32'h1);

    // ADDR register
    apb_write(12'h000, 32'h8000_03A5, e); chk("addr_wr_err", 32'(e), 32'h0);
    apb_read(12'h000, d, e); chk("addr_rd", d, 32'h8000_03A5);
    chk("addr_tba", 32'(tba), 32'h1);
    chk("addr_slvaddr", 32'(slvaddr), 32'h3A5);
    apb_write(12'h000, 32'h7FFF_FC5A, e);
    apb_read(12'h000, d, e); chk("addr_rd2", d, 32'h0000_005A);

    // TX FIFO fill and overflow
    for (int i = 0; i < 5; i++) begin
      apb_write(12'h00C, 32'h11 + 32'(i), e);
      chk("tx_push_err", 32'(e), (i == 4) ? 32'h1 : 32'h0);
    end
    apb_read(12'h004, d, e); chk("tx_level4", d, 32'h0000_0400);
    chk("tx_valid_full", 32'(tx_valid), 32'h1);

    // TX drain
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      chk("tx_drain_valid", 32'(tx_valid), 32'h1);
      chk("tx_drain_data", 32'(tx_data), 32'h11 + 32'(i));
    end
    @(negedge HCLK);
    chk("tx_drained", 32'(tx_valid), 32'h0);
    @(posedge HCLK); #1 tx_ready = 1'b0;

    // RX fill and overrun
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'hA0 + 8'(i);
      @(posedge HCLK); #1;
    end
    rx_valid = 1'b0;
    apb_read(12'h004, d, e); chk("rx_status", d, 32'h0004_000C);
    chk("rx_irq_masked", 32'(irq), 32'h0);
    for (int i = 0; i < 4; i++) begin
      apb_read(12'h010, d, e);
      chk("rx_pop_data", d, 32'hA0 + 32'(i));
      chk("rx_pop_err", 32'(e), 32'h0);
    end
    apb_read(12'h010, d, e); chk("rx_empty_data", d, 32'h0); chk("rx_empty_err", 32'(e), 32'h1);
    apb_write(12'h004, 32'h0000_000C, e);
    apb_read(12'h004, d, e); chk("rx_w1c", d, 32'h0);

    // Interrupts and W1C vs set
    apb_write(12'h008, 32'h0000_0001, e);
    apb_read(12'h008, d, e); chk("irq_en_rd", d, 32'h1);
    @(posedge HCLK); #1 nak = 1'b1;
    @(posedge HCLK); #1 nak = 1'b0;
    chk("irq_after_nak", 32'(irq), 32'h1);

    @(posedge HCLK); #1;
    psel = 1'b1; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h1; penable = 1'b0;
    @(posedge HCLK); #1;
    penable = 1'b1; nak = 1'b1;
    @(posedge HCLK); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; nak = 1'b0;
    apb_read(12'h004, d, e); chk("nak_set_wins", d, 32'h1);
    chk("irq_held", 32'(irq), 32'h1);

    apb_write(12'h004, 32'h0000_0001, e);
    chk("irq_cleared", 32'(irq), 32'h0);
    apb_read(12'h004, d, e); chk("nak_cleared", d, 32'h0);

    @(posedge HCLK); #1 tra = 1'b1;
    @(posedge HCLK); #1 tra = 1'b0;
    chk("tra_masked_irq", 32'(irq), 32'h0);
    apb_read(12'h004, d, e); chk("tra_set", d, 32'h2);

    // Unmapped addresses and ignored write
    apb_read(12'h020, d, e); chk("unmapped_data", d, 32'h0); chk("unmapped_err", 32'(e), 32'h1);
    apb_read(12'h104, d, e); chk("upper_bits_err", 32'(e), 32'h1);
    apb_write(12'h010, 32'h55, e); chk("rxdata_wr_err", 32'(e), 32'h0);

    // Reset mid-transfer
    apb_write(12'h00C, 32'h66, e);
    chk("pre_rst_valid", 32'(tx_valid), 32'h1);
    chk("pre_rst_data", 32'(tx_data), 32'h66);
    HRESETn = 1'b0;
    #2;
    chk("async_rst_valid", 32'(tx_valid), 32'h0);
    chk("async_rst_tba", 32'(tba), 32'h0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    apb_read(12'h004, d, e); chk("post_rst_status", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
